x1_cmd_sequencer: RTL and testbench

Multi-requester command sequencer for the Neuromorphic X1 32x32 array. It arbitrates PROGRAM/READ requests from NREQ clients round-robin and issues them as Wishbone master transactions to the X1 single-address shim. For reads it polls the shim until a result word arrives, skipping the empty marker 0xDEAD_C0DE. It returns one response per request to the originating client. It sits between on-chip requesters (host bridge, inference engine) and the X1 slave port.

---
 rtl/x1_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_x1_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/x1_cmd_sequencer.sv
// x1_cmd_sequencer: round-robin PROGRAM/READ sequencer mastering the X1 Wishbone shim
module x1_cmd_sequencer #(
  parameter int          NREQ     = 2,
  parameter logic [31:0] X1_ADDR  = 32'h3000_0000,
  parameter int          POLL_GAP = 8,
  parameter int          POLL_MAX = 64,
  parameter int          BUS_TO   = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_write,
  input  logic [5*NREQ-1:0] req_row,
  input  logic [5*NREQ-1:0] req_col,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_bit,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic [5:0]        stale_cnt,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic [31:0]       m_adr_o,
  output logic [31:0]       m_dat_o,
  input  logic [31:0]       m_dat_i,
  input  logic              m_ack_i
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int QW = $clog2(POLL_GAP + 1);
  localparam int TW = $clog2(BUS_TO);
  localparam logic [31:0] EMPTY = 32'hDEAD_C0DE;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_GAP, S_POLL} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, sel;
  logic            found, wr_q, wr_d, cyc_q, cyc_d, we_q, we_d, bit_q, bit_d, tmo;
  logic [31:0]     dat_q, dat_d;
  logic [NREQ-1:0] ready_q, ready_d, rsp_v_q, rsp_v_d;
  logic [1:0]      err_q, err_d;
  logic [5:0]      stale_q, stale_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [QW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   to_q, to_d;
  logic [4:0]      row_a [NREQ];
  logic [4:0]      col_a [NREQ];
  logic [7:0]      data_a [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign row_a[g]  = req_row[5*g +: 5];
    assign col_a[g]  = req_col[5*g +: 5];
    assign data_a[g] = req_data[8*g +: 8];
  end
  // first valid requester after the round-robin pointer, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_valid[IW'((int'(ptr_q) + i) % NREQ)]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end
  // next-state, bus and response decisions; any return to IDLE issues a response
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    stale_d = stale_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
    to_d    = to_q;
    ready_d = '0;
    rsp_v_d = '0;
    bit_d   = 1'b0;
    err_d   = 2'b00;
    tmo     = (state_q == S_CMD || state_q == S_POLL) && !m_ack_i && to_q == TW'(BUS_TO - 1);
    case (state_q)
      S_IDLE: if (found) begin
        state_d      = S_CMD;
        ptr_d        = sel;
        gnt_d        = sel;
        wr_d         = req_write[sel];
        dat_d        = {req_write[sel] ? 2'b11 : 2'b01, row_a[sel], col_a[sel], 12'b0,
                        req_write[sel] ? data_a[sel] : 8'h00};
        cyc_d        = 1'b1;
        we_d         = 1'b1;
        to_d         = '0;
        ready_d[sel] = 1'b1;
      end
      S_CMD: if (m_ack_i) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        poll_d  = '0;
        gap_d   = '0;
        state_d = wr_q ? S_IDLE : S_GAP;
      end else to_d = to_q + 1'b1;
      S_GAP: if (gap_q == QW'(POLL_GAP - 1)) begin
        state_d = S_POLL;
        cyc_d   = 1'b1;
        to_d    = '0;
      end else gap_d = gap_q + 1'b1;
      S_POLL: if (m_ack_i) begin
        cyc_d   = 1'b0;
        gap_d   = '0;
        state_d = S_GAP;
        if (m_dat_i == EMPTY) begin
          poll_d = poll_q + 1'b1;
          if (poll_q == PW'(POLL_MAX - 1)) begin
            err_d   = 2'b01;
            stale_d = (&stale_q) ? stale_q : stale_q + 1'b1;
            state_d = S_IDLE;
          end
        end else if (stale_q != 6'd0) stale_d = stale_q - 1'b1;
        else begin
          err_d   = (|m_dat_i[31:1]) ? 2'b11 : 2'b00;
          bit_d   = ~|m_dat_i[31:1] & m_dat_i[0];
          state_d = S_IDLE;
        end
      end else to_d = to_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 2'b10;
      state_d = S_IDLE;
    end
    if (state_q != S_IDLE && state_d == S_IDLE) rsp_v_d[gnt_q] = 1'b1;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      stale_q <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      ready_q <= '0;
      rsp_v_q <= '0;
      bit_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      stale_q <= stale_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      ready_q <= ready_d;
      rsp_v_q <= rsp_v_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = ready_q;
  assign rsp_valid = rsp_v_q;
  assign rsp_bit   = bit_q;
  assign rsp_err   = err_q;
  assign busy      = state_q != S_IDLE;
  assign stale_cnt = stale_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_we_o    = we_q;
  assign m_sel_o   = 4'hF;
  assign m_adr_o   = X1_ADDR;
  assign m_dat_o   = dat_q;
endmodule

// File: tb/tb_x1_cmd_sequencer.sv
// tb_x1_cmd_sequencer: directed and random requests checked against a cell-array model
module tb_x1_cmd_sequencer;
  localparam int NREQ = 2;
  localparam logic [31:0] ADDR = 32'h3000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [5*NREQ-1:0] req_row = '0, req_col = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic rsp_bit, busy, m_cyc_o, m_stb_o, m_we_o;
  logic [1:0] rsp_err;
  logic [5:0] stale_cnt;
  logic [3:0] m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] sdat = '0;
  logic ack = 1'b0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  x1_cmd_sequencer dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_row(req_row), .req_col(req_col), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_err(rsp_err), .busy(busy),
    .stale_cnt(stale_cnt), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(sdat), .m_ack_i(ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // X1 shim model: commands execute in order after a latency, reads queue results
  logic smem [32][32];
  logic mem [32][32];
  logic [31:0] cq[$];
  int lq[$];
  logic rq[$];
  logic [31:0] cur;
  bit cur_v = 0, noack = 0, force5 = 0, auto_chk = 1;
  int rem = 0, wait_n = 0, dly = 0, rd_lat = 44, wr_lat = 200, dead_n = 0, cyc_n = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      cq.delete(); lq.delete(); rq.delete();
      cur_v = 0; ack = 1'b0; wait_n = 0;
    end else begin
      if (cur_v) begin
        if (rem > 0) rem--;
        else begin
          if (cur[31:30] == 2'b11) smem[cur[29:25]][cur[24:20]] = cur[7:0] > 8'h7F;
          else rq.push_back(smem[cur[29:25]][cur[24:20]]);
          cur_v = 0;
        end
      end else if (cq.size() > 0) begin
        cur = cq.pop_front(); rem = lq.pop_front(); cur_v = 1;
      end
      if (ack) ack = 1'b0;
      else if (m_cyc_o && m_stb_o && !noack) begin
        if (wait_n < dly) wait_n++;
        else begin
          ack = 1'b1; wait_n = 0; dly = $urandom_range(0, 2);
          if (m_we_o) begin
            cq.push_back(m_dat_o);
            lq.push_back(m_dat_o[31:30] == 2'b11 ? wr_lat : rd_lat);
          end else if (force5) sdat = 32'h5;
          else if (rq.size() > 0) sdat = {31'b0, rq.pop_front()};
          else begin sdat = 32'hDEAD_C0DE; dead_n++; end
        end
      end
    end
  end
  // reference: round-robin grant order and array contents, in request acceptance order
  int last_g = NREQ - 1, g, gseq[$];
  logic [NREQ-1:0] vprev = '0;
  logic [1:0] exp_err [NREQ];
  logic exp_bit [NREQ];
  logic [4:0] mr, mc;
  logic [7:0] md;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      last_g = NREQ - 1; vprev = '0;
    end else begin
      if (m_cyc_o) cyc_n++;
      if (|req_ready || |rsp_valid) chk("ready_rsp_overlap", {31'b0, |req_ready && |rsp_valid}, 0);
      if (|req_ready) begin
        g = -1;
        for (int i = 1; i <= NREQ; i++) if (g < 0 && vprev[(last_g + i) % NREQ]) g = (last_g + i) % NREQ;
        if (g < 0) g = 0;
        chk("grant", {30'b0, req_ready}, 32'(1 << g));
        last_g = g;
        gseq.push_back(g);
        if (auto_chk) begin
          mr = req_row[5*g +: 5]; mc = req_col[5*g +: 5]; md = req_data[8*g +: 8];
          exp_err[g] = 2'b00;
          if (req_write[g]) begin mem[mr][mc] = md > 8'h7F; exp_bit[g] = 1'b0; end
          else exp_bit[g] = mem[mr][mc];
        end
      end
      if (|rsp_valid) begin
        chk("rsp_onehot", {31'b0, $onehot(rsp_valid)}, 1);
        for (int k = 0; k < NREQ; k++) if (rsp_valid[k] && auto_chk) begin
          chk("rsp_err", {30'b0, rsp_err}, {30'b0, exp_err[k]});
          chk("rsp_bit", {31'b0, rsp_bit}, {31'b0, exp_bit[k]});
        end
      end
      vprev = req_valid;
    end
  end
  task automatic do_req(input int k, input bit w, input int r, input int c, input int d,
                        output logic [1:0] e, output logic b);
    int n;
    @(posedge clk); #1;
    req_write[k] = w; req_row[5*k +: 5] = 5'(r); req_col[5*k +: 5] = 5'(c);
    req_data[8*k +: 8] = 8'(d); req_valid[k] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[k] && n < 4000);
    chk("ready_seen", {31'b0, req_ready[k]}, 1);
    @(posedge clk); #1 req_valid[k] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[k] && n < 8000);
    chk("rsp_seen", {31'b0, rsp_valid[k]}, 1);
    e = rsp_err; b = rsp_bit;
    @(negedge clk);
    chk("rsp_pulse", {31'b0, rsp_valid[k]}, 0);
    chk("rsp_idle", {29'b0, rsp_err, rsp_bit}, 0);
  endtask
  logic [1:0] e0, e1;
  logic b0, b1;
  initial begin
    logic [1:0] e;
    logic b;
    int n;
    int exp_g [4] = '{0, 1, 0, 1};
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) begin mem[r][c] = 1'b0; smem[r][c] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'b0, m_cyc_o}, 0);
    chk("rst_stb", {31'b0, m_stb_o}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_sel", {28'b0, m_sel_o}, 32'hF);
    chk("rst_adr", m_adr_o, ADDR);
    chk("rst_stale", {26'b0, stale_cnt}, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_io", {28'b0, req_ready, rsp_valid}, 0);
    #2 rst_n = 1'b1;
    do_req(0, 1, 3, 7, 8'h80, e, b);
    chk("prog_err", {30'b0, e}, 0);
    chk("prog_bit", {31'b0, b}, 0);
    dead_n = 0;
    do_req(0, 0, 3, 7, 0, e, b);
    chk("rd1_err", {30'b0, e}, 0);
    chk("rd1_bit", {31'b0, b}, 1);
    chk("rd1_empty_polls", {31'b0, dead_n > 0}, 1);
    do_req(1, 1, 3, 7, 8'h7F, e, b);
    do_req(1, 0, 3, 7, 0, e, b);
    chk("rd_7f_bit", {31'b0, b}, 0);
    do_req(0, 1, 31, 31, 8'hFF, e, b);
    do_req(1, 0, 31, 31, 0, e, b);
    chk("rd_edge_bit", {31'b0, b}, 1);
    wr_lat = 100;
    gseq.delete();
    fork
      begin do_req(0, 0, 3, 7, 0, e0, b0); do_req(0, 1, 1, 2, 8'hF0, e0, b0); end
      begin do_req(1, 1, 4, 4, 8'h90, e1, b1); do_req(1, 0, 31, 31, 0, e1, b1); end
    join
    chk("rr_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("rr_order", gseq[i], exp_g[i]);
    do_req(1, 1, 5, 5, 8'hC0, e, b);
    rd_lat = 700; auto_chk = 0;
    do_req(0, 0, 5, 5, 0, e, b);
    chk("poll_to_err", {30'b0, e}, 2'b01);
    chk("poll_to_stale", {26'b0, stale_cnt}, 1);
    rd_lat = 44; auto_chk = 1;
    do_req(1, 1, 5, 5, 8'h10, e, b);
    do_req(0, 0, 5, 5, 0, e, b);
    chk("stale_read_bit", {31'b0, b}, 0);
    chk("stale_cleared", {26'b0, stale_cnt}, 0);
    noack = 1; auto_chk = 0; cyc_n = 0;
    do_req(1, 1, 1, 1, 8'hFF, e, b);
    noack = 0;
    chk("bus_to_err", {30'b0, e}, 2'b10);
    chk("bus_to_cycles", cyc_n, 16);
    chk("bus_to_busy", {31'b0, busy}, 0);
    force5 = 1;
    do_req(0, 0, 2, 2, 0, e, b);
    force5 = 0;
    chk("bad_data_err", {30'b0, e}, 2'b11);
    @(posedge clk); #1;
    req_write[0] = 1'b0; req_row[4:0] = 5'd3; req_col[4:0] = 5'd7; req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 100);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (m_cyc_o && n < 100);
    repeat (3) @(negedge clk);
    chk("gap_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_cyc", {30'b0, m_cyc_o, m_stb_o}, 0);
    chk("arst_rsp", {30'b0, rsp_valid}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    auto_chk = 1;
    gseq.delete();
    fork
      do_req(0, 0, 3, 7, 0, e0, b0);
      do_req(1, 0, 31, 31, 0, e1, b1);
    join
    chk("post_rst_first", gseq.size() > 0 ? gseq[0] : -1, 0);
    rd_lat = 4; wr_lat = 6;
    fork
      for (int i = 0; i < 12; i++) begin
        do_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), e0, b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int j = 0; j < 12; j++) begin
        do_req(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), e1, b1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
endmodule
